// File: rtl/trace_pkg.sv
// Shared types for the trace buffer: entry kinds, entry header record and drop-counter width.
package trace_pkg;

    localparam int TAG_W  = 9;
    localparam int DROP_W = 8;

    typedef enum logic {
        KIND_REG = 1'b0,
        KIND_MEM = 1'b1
    } kind_t;

    // Data width is a module parameter, so the full {kind, tag, data} entry
    // is built in trace_buffer from this header plus a DATA_W payload.
    typedef struct packed {
        kind_t             kind;
        logic [TAG_W-1:0]  tag;
    } entry_hdr_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Show-ahead output stream of the trace buffer (head entry plus valid/ready).
interface trace_buffer_if
    import trace_pkg::*;
#(
    parameter int DATA_W = 32
) ();

    logic              out_valid;
    logic              out_ready;
    kind_t             out_kind;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_kind,
        output out_tag,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_kind,
        input  out_tag,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/trace_fifo2w.sv
// Dual-push, single-pop, show-ahead FIFO; the caller guarantees push_n never exceeds free space.
module trace_fifo2w #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push_n,
    input  logic [WIDTH-1:0]       din0,
    input  logic [WIDTH-1:0]       din1,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wp] <= din0;
        if (push_n == 2'd2) mem[wp + AW'(1)] <= din1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push_n);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/trace_buffer.sv
// Captures core register-file and data-memory writes into a show-ahead trace FIFO,
// dropping events that do not fit and counting them.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reg_write_sig,
    input  logic [4:0]             reg_num,
    input  logic [DATA_W-1:0]      reg_data,
    input  logic                   wr,
    input  logic [8:0]             addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   clr,
    trace_buffer_if.master         stream,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        entry_hdr_t        hdr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t      reg_ent, mem_ent, din0, din1, head;
    logic        reg_ev, mem_ev, pop;
    logic [1:0]  n_ev, push_n, n_drop;
    logic [CW-1:0] free;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [1:0]        b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W + 1)'(b);
        return s[DROP_W] ? '1 : s[DROP_W-1:0];
    endfunction

    assign reg_ev  = reg_write_sig && (reg_num != 5'd0);
    assign mem_ev  = wr;
    assign reg_ent = {KIND_REG, 4'b0, reg_num, reg_data};
    assign mem_ent = {KIND_MEM, addr, wr_data};

    // Room is judged before this cycle's pop; the register event always takes the first slot.
    assign n_ev   = {1'b0, reg_ev} + {1'b0, mem_ev};
    assign free   = CW'(DEPTH) - count;
    assign push_n = (free >= CW'(n_ev)) ? n_ev : free[1:0];
    assign n_drop = n_ev - push_n;
    assign din0   = reg_ev ? reg_ent : mem_ent;
    assign din1   = mem_ent;

    assign stream.out_valid = (count != '0);
    assign pop              = stream.out_valid && stream.out_ready;
    assign stream.out_kind  = head.hdr.kind;
    assign stream.out_tag   = head.hdr.tag;
    assign stream.out_data  = head.data;

    trace_fifo2w #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_n (push_n),
        .din0   (din0),
        .din1   (din1),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    // A clear in the same cycle as drops discards those drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (n_drop != 2'd0) begin
            overflow <= 1'b1;
            drop_cnt <= sat_add(drop_cnt, n_drop);
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic        clr;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    trace_buffer_if #(.DATA_W(DATA_W)) bus ();

    trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .addr          (addr),
        .wr_data       (wr_data),
        .clr           (clr),
        .stream        (bus),
        .count         (count),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic        kind;
        logic [8:0]  tag;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    ent_t m_ev[$];
    ent_t m_e;
    int   m_free;
    int   m_drops;
    int   m_drop = 0;
    bit   m_ovf  = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a queue of entries, free space taken before the pop.
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            m_ev.delete();
            m_free  = DEPTH - q.size();
            m_drops = 0;
            if (reg_write_sig && reg_num != 5'd0) begin
                m_e.kind = 1'b0; m_e.tag = {4'b0, reg_num}; m_e.data = reg_data;
                m_ev.push_back(m_e);
            end
            if (wr) begin
                m_e.kind = 1'b1; m_e.tag = addr; m_e.data = wr_data;
                m_ev.push_back(m_e);
            end
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            foreach (m_ev[i]) begin
                if (i < m_free) q.push_back(m_ev[i]);
                else m_drops++;
            end
            if (clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end else if (m_drops > 0) begin
                m_ovf  = 1'b1;
                m_drop = (m_drop + m_drops > 255) ? 255 : m_drop + m_drops;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("model_count", count, q.size());
            check("model_valid", bus.out_valid, q.size() != 0);
            check("model_overflow", overflow, m_ovf);
            check("model_drop_cnt", drop_cnt, m_drop);
            if (q.size() != 0) begin
                check("model_kind", bus.out_kind, q[0].kind);
                check("model_tag", bus.out_tag, q[0].tag);
                check("model_data", bus.out_data, q[0].data);
            end
        end
    end

    task automatic set_in(input bit rws, input logic [4:0] rn, input logic [31:0] rd,
                          input bit w, input logic [8:0] a, input logic [31:0] wd);
        reg_write_sig = rws; reg_num = rn; reg_data = rd;
        wr = w; addr = a; wr_data = wd;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_head(input string nm, input logic k, input logic [8:0] t, input logic [31:0] d);
        check({nm, "_kind"}, bus.out_kind, k);
        check({nm, "_tag"}, bus.out_tag, t);
        check({nm, "_data"}, bus.out_data, d);
    endtask

    int pct;

    initial begin
        reset = 1'b0; clr = 1'b0; bus.out_ready = 1'b0;
        idle();
        cyc(2);
        check("rst_count", count, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // First event lands on the first edge after reset release.
        reset = 1'b1; chk_en = 1'b1;
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'd0, 32'd0);
        cyc(); idle();
        check("single_valid", bus.out_valid, 1);
        check("single_count", count, 1);
        check_head("single", 1'b0, 9'd5, 32'hDEADBEEF);
        bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
        check("single_pop_count", count, 0);
        check("single_pop_valid", bus.out_valid, 0);

        set_in(1'b1, 5'd3, 32'h11, 1'b1, 9'h1F0, 32'h22);
        cyc(); idle();
        check("dual_count", count, 2);
        check_head("dual_first", 1'b0, 9'd3, 32'h11);
        bus.out_ready = 1'b1; cyc();
        check("dual_count1", count, 1);
        check_head("dual_second", 1'b1, 9'h1F0, 32'h22);
        cyc(); bus.out_ready = 1'b0;
        check("dual_count0", count, 0);

        set_in(1'b1, 5'd0, 32'h55, 1'b0, 9'd0, 32'd0);
        cyc(); idle();
        check("x0_count", count, 0);
        check("x0_overflow", overflow, 0);

        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 9'd0, 32'd0);
            cyc();
        end
        set_in(1'b1, 5'd9, 32'hAA, 1'b1, 9'h100, 32'hBB);
        cyc(); idle();
        check("fill_count", count, 8);
        check("fill_overflow", overflow, 1);
        check("fill_drop_cnt", drop_cnt, 1);

        bus.out_ready = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 9'd5, 32'h77);
        cyc(); idle(); bus.out_ready = 1'b0;
        check("full_pop_count", count, 7);
        check("full_pop_drop_cnt", drop_cnt, 2);
        check_head("full_pop_head", 1'b0, 9'd2, 32'h101);
        clr = 1'b1; cyc(); clr = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);
        bus.out_ready = 1'b1; cyc(6); bus.out_ready = 1'b0;
        check("kept_count", count, 1);
        check_head("kept_reg", 1'b0, 9'd9, 32'hAA);
        bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
        check("drain_count", count, 0);

        // 4 cycles fill the FIFO, then 150 dual events drop 300.
        repeat (154) begin
            set_in(1'b1, 5'd7, $urandom, 1'b1, 9'h0AB, $urandom);
            cyc();
        end
        idle();
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_overflow", overflow, 1);
        check("sat_count", count, 8);
        clr = 1'b1;
        set_in(1'b1, 5'd7, 32'h1, 1'b1, 9'h0AB, 32'h2);
        cyc(); clr = 1'b0; idle();
        check("clr_wins_drop_cnt", drop_cnt, 0);
        check("clr_wins_overflow", overflow, 0);
        set_in(1'b1, 5'd7, 32'h1, 1'b1, 9'h0AB, 32'h2);
        cyc(); idle();
        check("after_clr_drop_cnt", drop_cnt, 2);

        #1 reset = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
        cyc(); reset = 1'b1;

        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
            for (int i = 0; i < 1000; i++) begin
                set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom);
                bus.out_ready = ($urandom_range(0, 99) < pct);
                clr = ($urandom_range(0, 49) == 0);
                if (ph == 1 && i == 500) begin
                    #2 reset = 1'b0;
                    #1;
                    check("rand_rst_count", count, 0);
                    check("rand_rst_valid", bus.out_valid, 0);
                    cyc(); reset = 1'b1;
                end else begin
                    cyc();
                end
            end
        end
        idle(); clr = 1'b0;
        bus.out_ready = 1'b1; cyc(DEPTH + 2); bus.out_ready = 1'b0;
        check("final_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
